// File: rtl/button_decoder.sv
// ============================================================================
//  Module   : button_decoder
//  Purpose  : Synchronise and debounce btnU/btnL/btnR; one 2-bit key pulse per press.
//  Options  : define KEY_AUTOREPEAT_EN to enable auto-repeat while a key is held.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_decoder #(
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int REPEAT_DELAY    = 20000000,
  parameter int REPEAT_PERIOD   = 8000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  output logic [1:0] key_code,
  output logic       key_held
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  logic [2:0]       meta_q, sync_q;
  logic [1:0]       state_q, state_d;
  logic [2:0]       pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       key_code_q, key_code_d;
  logic             rep_fire;

  function automatic logic [1:0] code_of(input logic [2:0] p);
    if (p[2])      return 2'b11;
    else if (p[1]) return 2'b01;
    else if (p[0]) return 2'b10;
    else           return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= {btnU, btnL, btnR};
      sync_q <= meta_q;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // first_q selects the initial delay until the first repeat has fired
  logic first_q, first_d;

  assign rep_fire = (state_q == ST_HOLD) && (sync_q == pat_q) &&
                    (cnt_q == (first_q ? RD_LAST : RP_LAST));
`else
  assign rep_fire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pat_q      <= 3'b000;
      cnt_q      <= '0;
      key_code_q <= 2'b00;
`ifdef KEY_AUTOREPEAT_EN
      first_q    <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
`ifdef KEY_AUTOREPEAT_EN
      first_q    <= first_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
`ifdef KEY_AUTOREPEAT_EN
    first_d = first_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sync_q != 3'b000) begin
          state_d = ST_QUAL;
          pat_d   = sync_q;
          cnt_d   = '0;
        end
      end
      ST_QUAL: begin
        if (sync_q == 3'b000) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sync_q != pat_q) begin
          pat_d = sync_q;
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
          first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (sync_q == 3'b000) begin
          state_d = ST_REL;
          cnt_d   = '0;
        end else if (sync_q != pat_q) begin
          pat_d = sync_q;
          cnt_d = '0;
`ifdef KEY_AUTOREPEAT_EN
          first_d = 1'b1;
        end else if (rep_fire) begin
          cnt_d   = '0;
          first_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
`endif
        end
      end
      default: begin
        // Release bounce returns to HOLD silently; only a full quiet period reaches IDLE
        if (sync_q != 3'b000) begin
          state_d = ST_HOLD;
          pat_d   = sync_q;
          cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
          first_d = 1'b1;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    key_code_d = 2'b00;
    key_held   = (state_q == ST_HOLD);
    if ((state_q == ST_QUAL) && (state_d == ST_HOLD)) begin
      key_code_d = code_of(pat_q);
    end else if (rep_fire) begin
      key_code_d = code_of(pat_q);
    end
  end

  assign key_code = key_code_q;

endmodule

`default_nettype wire

// File: tb/tb_button_decoder.sv
// ============================================================================
//  Module   : tb_button_decoder
//  Purpose  : Directed self-checking bench for button_decoder (D=8, RD=40, RP=16).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnU = 1'b0;
  logic       btnL = 1'b0;
  logic       btnR = 1'b0;
  logic [1:0] key_code;
  logic       key_held;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         t0;
  int         pcyc[$];
  logic [1:0] pcode[$];
  int         exp_dt[$];
  logic [1:0] exp_code;

  button_decoder #(
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (40),
    .REPEAT_PERIOD  (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btnU    (btnU),
    .btnL    (btnL),
    .btnR    (btnR),
    .key_code(key_code),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Log every non-zero key_code with the negedge index it was seen on
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (key_code !== 2'b00) begin
      pcyc.push_back(cyc);
      pcode.push_back(key_code);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input int base);
    chk({tag, "_count"}, pcyc.size(), exp_dt.size());
    for (int i = 0; i < exp_dt.size() && i < pcyc.size(); i++) begin
      chk({tag, "_time"}, pcyc[i] - base, exp_dt[i]);
      chk({tag, "_code"}, 32'(pcode[i]), 32'(exp_code));
    end
    pcyc.delete();
    pcode.delete();
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_held", 32'(key_held), 0);
    rst = 1'b0;
    step(5);
    chk("idle_code", 32'(key_code), 0);
    chk("idle_held", 32'(key_held), 0);

    // 1: clean L press held 100 clk
    t0 = cyc; btnL = 1'b1;
    step(10);
    chk("t1_held_before", 32'(key_held), 0);
    step(1);
    chk("t1_held_at", 32'(key_held), 1);
    step(89);
    chk("t1_held_long", 32'(key_held), 1);
    btnL = 1'b0;
    step(20);
    chk("t1_held_rel", 32'(key_held), 0);
`ifdef KEY_AUTOREPEAT_EN
    exp_dt = '{11, 51, 67, 83, 99};
`else
    exp_dt = '{11};
`endif
    exp_code = 2'b01;
    check_pulses("t1", t0);

    // Short glitch: no event
    t0 = cyc; btnL = 1'b1;
    step(5);
    btnL = 1'b0;
    step(15);
    chk("glitch_held", 32'(key_held), 0);
    exp_dt = {};
    check_pulses("glitch", t0);

    // 2: R bounces every 3 clk for 30 clk, then stable
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      btnR = (i % 2 == 0);
      step(3);
    end
    btnR = 1'b1;
    step(20);
    btnR = 1'b0;
    step(20);
    exp_dt = '{41};
    exp_code = 2'b10;
    check_pulses("t2", t0);

    // 3: U+L together, then L+R together
    t0 = cyc; btnU = 1'b1; btnL = 1'b1;
    step(20);
    btnU = 1'b0; btnL = 1'b0;
    step(20);
    exp_dt = '{11};
    exp_code = 2'b11;
    check_pulses("t3_ul", t0);
    t0 = cyc; btnL = 1'b1; btnR = 1'b1;
    step(20);
    btnL = 1'b0; btnR = 1'b0;
    step(20);
    exp_dt = '{11};
    exp_code = 2'b01;
    check_pulses("t3_lr", t0);

    // 4: L then R 4 clk later; bounce during release
    t0 = cyc; btnL = 1'b1;
    step(4);
    btnR = 1'b1;
    step(21);
    btnL = 1'b0; btnR = 1'b0;
    step(5);
    chk("t4_held_rel", 32'(key_held), 0);
    btnL = 1'b1;
    step(4);
    chk("t4_held_bounce", 32'(key_held), 1);
    step(1);
    btnL = 1'b0;
    step(25);
    chk("t4_held_end", 32'(key_held), 0);
    exp_dt = '{15};
    exp_code = 2'b01;
    check_pulses("t4", t0);

    // 5: reset during QUAL with U held
    t0 = cyc; btnU = 1'b1;
    step(8);
    chk("t5_held_qual", 32'(key_held), 0);
    rst = 1'b1;
    step(1);
    chk("t5_rst_code", 32'(key_code), 0);
    chk("t5_rst_held", 32'(key_held), 0);
    step(2);
    chk("t5_rst_held2", 32'(key_held), 0);
    rst = 1'b0;
    step(30);
    btnU = 1'b0;
    step(20);
    exp_dt = '{22};
    exp_code = 2'b11;
    check_pulses("t5", t0);

    // 6: hold R 120 clk
    t0 = cyc; btnR = 1'b1;
    step(120);
    btnR = 1'b0;
    step(20);
    chk("t6_held_end", 32'(key_held), 0);
`ifdef KEY_AUTOREPEAT_EN
    exp_dt = '{11, 51, 67, 83, 99, 115};
`else
    exp_dt = '{11};
`endif
    exp_code = 2'b10;
    check_pulses("t6", t0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
